// File: rtl/boot_pkg.sv
// Shared types and constants for the boot controller: FSM states, error codes and default widths.
package boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StStart,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_CNT_WIDTH  = 16;
    localparam int unsigned DEF_MAX_CYCLES = 1000;

endpackage

// File: rtl/boot_ctrl.sv
// Boot controller: streams a program into instruction memory, starts the processor,
// and times the run until stop or timeout.
module boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  im_wr,
    output logic [ADDR_WIDTH-1:0] im_w_addr,
    output logic [DATA_WIDTH-1:0] im_w_data,
    output logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam logic [CNT_WIDTH-1:0]  MaxCnt  = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LastAdr = {ADDR_WIDTH{1'b1}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  im_wr_q, im_wr_d;
    logic [ADDR_WIDTH-1:0] im_w_addr_q, im_w_addr_d;
    logic [DATA_WIDTH-1:0] im_w_data_q, im_w_data_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic [CNT_WIDTH-1:0]  cc_q, cc_d;
    logic                  hs;

    assign s_ready = (state_q == StLoad);
    assign busy    = !((state_q == StIdle) || (state_q == StDone));
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        im_wr_d     = 1'b0;
        im_w_addr_d = im_w_addr_q;
        im_w_data_d = im_w_data_q;
        start_d     = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        wc_d        = wc_q;
        cc_d        = cc_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (load_req) begin
                    state_d = StLoad;
                    addr_d  = '0;
                    wc_d    = '0;
                    cc_d    = '0;
                    err_d   = ERR_NONE;
                    done_d  = 1'b0;
                end
            end
            StLoad: begin
                if (hs) begin
                    im_wr_d     = 1'b1;
                    im_w_addr_d = addr_q;
                    im_w_data_d = s_data;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    wc_d        = wc_q + (ADDR_WIDTH + 1)'(1);
                    if (s_last) begin
                        state_d = StFlush;
                    end else if (addr_q == LastAdr) begin
                        // Memory full without a last marker: keep the write, never start.
                        err_d   = ERR_OVF;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StFlush: begin
                // Registered so the pulse lands exactly in the START cycle.
                start_d = 1'b1;
                state_d = StStart;
            end
            StStart: begin
                cc_d    = '0;
                state_d = StRun;
            end
            StRun: begin
                if (stop) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (cc_q == MaxCnt) begin
                    err_d   = ERR_TMO;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cc_d = cc_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            im_wr_q     <= 1'b0;
            im_w_addr_q <= '0;
            im_w_data_q <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_NONE;
            wc_q        <= '0;
            cc_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            im_wr_q     <= im_wr_d;
            im_w_addr_q <= im_w_addr_d;
            im_w_data_q <= im_w_data_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wc_q        <= wc_d;
            cc_q        <= cc_d;
        end
    end

    assign im_wr       = im_wr_q;
    assign im_w_addr   = im_w_addr_q;
    assign im_w_data   = im_w_data_q;
    assign start       = start_q;
    assign done        = done_q;
    assign err_code    = err_q;
    assign word_count  = wc_q;
    assign cycle_count = cc_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: vector table, hand-written reset sequence and
// randomized loads checked against a behavioural model.
module tb_boot_ctrl;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int MAXC = 20;

    logic          clk = 1'b0;
    logic          rst, load_req, s_valid, s_last, stop;
    logic [DW-1:0] s_data;
    logic          s_ready, im_wr, start, busy, done;
    logic [AW-1:0] im_w_addr;
    logic [DW-1:0] im_w_data;
    logic [1:0]    err_code;
    logic [AW:0]   word_count;
    logic [CW-1:0] cycle_count;

    boot_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .im_wr      (im_wr),
        .im_w_addr  (im_w_addr),
        .im_w_data  (im_w_data),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code),
        .word_count (word_count),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Monitor: memory image, write contiguity/latency, start and done events.
    bit            hs_at[int];
    logic [DW-1:0] mem[256];
    bit            wflag[256];
    int            exp_addr = 0, wr_cnt = 0, wr_err = 0, start_cnt = 0, done_tick = 0;
    logic          done_prev = 1'b0;
    logic [DW-1:0] prog[300];

    always @(negedge clk) begin
        if (im_wr === 1'b1) begin
            if (im_w_addr !== exp_addr[AW-1:0]) wr_err++;
            mem[im_w_addr]   = im_w_data;
            wflag[im_w_addr] = 1'b1;
            exp_addr++;
            wr_cnt++;
        end
        if (im_wr !== (hs_at.exists(tick - 1) != 0)) wr_err++;
        if (start === 1'b1) start_cnt++;
        if (done === 1'b1 && done_prev !== 1'b1) done_tick = tick;
        done_prev = done;
    end

    // Expected outcome of a load+run from the rules, not the implementation.
    task automatic model(input int n, input bit last, input int k,
                         output int e_wc, output int e_err, output int e_cc, output bit e_st);
        bit ovf;
        ovf = (n > 256) || (n == 256 && !last);
        e_wc = ovf ? 256 : n;
        if (ovf) begin
            e_err = 1; e_cc = 0; e_st = 1'b0;
        end else begin
            e_st  = 1'b1;
            e_cc  = (k <= MAXC) ? k : MAXC;
            e_err = (k <= MAXC) ? 0 : 2;
        end
    endtask

    task automatic do_load(input string tag, input int n, input int gap, input bit last,
                           output int last_hs);
        int idx, c;
        idx = 0;
        c = 0;
        last_hs = -1;
        @(negedge clk);
        exp_addr = 0;
        wr_cnt = 0;
        wr_err = 0;
        foreach (wflag[i]) wflag[i] = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk({tag, "_clear"}, {word_count, cycle_count, err_code, done, s_ready, busy}, 64'h3);
        while (idx < n && c < 4 * n + 40 && done !== 1'b1) begin
            logic v;
            case (gap)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data  = prog[idx];
            s_last  = last && (idx == n - 1);
            if (v && s_ready === 1'b1) begin
                hs_at[tick] = 1'b1;
                last_hs = tick;
                idx++;
            end
            c++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 16'($urandom);
        if (idx < n && done !== 1'b1) chk({tag, "_load_budget"}, idx, n);
    endtask

    task automatic run_check(input string tag, input int n, input int gap, input bit last,
                             input int k, input int e_wc, input int e_err, input int e_cc,
                             input bit e_st);
        int lh, s, t, st0, mism;
        st0 = start_cnt;
        s = 0;
        do_load(tag, n, gap, last, lh);
        if (e_st) begin
            t = 0;
            while (start !== 1'b1 && t < 10) begin
                @(negedge clk);
                t++;
            end
            s = tick;
            chk({tag, "_start_lat"}, tick - lh, 2);
            for (int i = 0; i <= k; i++) begin
                @(negedge clk);
                load_req = (k >= 3 && i == 1);
            end
            load_req = 1'b0;
            stop = 1'b1;
        end
        t = 0;
        while (done !== 1'b1 && t < MAXC + 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        stop = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wc"}, word_count, e_wc);
        chk({tag, "_err"}, err_code, e_err);
        chk({tag, "_cc"}, cycle_count, e_cc);
        chk({tag, "_starts"}, start_cnt - st0, e_st ? 1 : 0);
        chk({tag, "_writes"}, wr_cnt, e_wc);
        chk({tag, "_wr_order"}, wr_err, 0);
        mism = 0;
        for (int a = 0; a < e_wc && a < 256; a++)
            if (!wflag[a] || mem[a] !== prog[a]) mism++;
        chk({tag, "_mem"}, mism, 0);
        if (e_st) chk({tag, "_done_lat"}, done_tick - s, ((k <= MAXC) ? k : MAXC) + 2);
    endtask

    typedef struct {
        int n;
        int gap;
        bit last;
        int k;
        int wc;
        int err;
        int cc;
        bit st;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int lh, st0, e_wc, e_err, e_cc, n, gap, k;
        bit e_st;
        rst = 1'b1; load_req = 1'b0; s_valid = 1'b0; s_last = 1'b0; stop = 1'b0; s_data = '0;

        tbl[0] = '{4,   0, 1'b1, 10, 4,   0, 10, 1'b1};
        tbl[1] = '{4,   1, 1'b1, 3,  4,   0, 3,  1'b1};
        tbl[2] = '{1,   0, 1'b1, 0,  1,   0, 0,  1'b1};
        tbl[3] = '{257, 0, 1'b0, 0,  256, 1, 0,  1'b0};
        tbl[4] = '{5,   2, 1'b1, 30, 5,   2, 20, 1'b1};
        tbl[5] = '{6,   0, 1'b1, 20, 6,   0, 20, 1'b1};
        tbl[6] = '{256, 2, 1'b1, 5,  256, 0, 5,  1'b1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {s_ready, im_wr, im_w_addr, im_w_data, start, busy, done,
                              err_code, word_count, cycle_count}, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 300; i++)
                prog[i] = (v < 2 && i < 4) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
            run_check($sformatf("vec%0d", v), tbl[v].n, tbl[v].gap, tbl[v].last, tbl[v].k,
                      tbl[v].wc, tbl[v].err, tbl[v].cc, tbl[v].st);
        end

        // Reset after two of four words, then a fresh single-word load.
        for (int i = 0; i < 300; i++) prog[i] = 16'($urandom);
        st0 = start_cnt;
        do_load("rst", 2, 0, 1'b0, lh);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {s_ready, im_wr, im_w_addr, im_w_data, start, busy, done,
                            err_code, word_count, cycle_count}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_partial_writes", wr_cnt, 2);
        chk("rst_no_start", start_cnt - st0, 0);
        run_check("after_rst", 1, 0, 1'b1, 2, 1, 0, 2, 1'b1);

        for (int r = 0; r < 8; r++) begin
            n   = $urandom_range(1, 40);
            gap = $urandom_range(0, 2);
            k   = $urandom_range(0, 26);
            for (int i = 0; i < 300; i++) prog[i] = 16'($urandom);
            model(n, 1'b1, k, e_wc, e_err, e_cc, e_st);
            run_check($sformatf("rnd%0d", r), n, gap, 1'b1, k, e_wc, e_err, e_cc, e_st);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot controller upstream of the pipelined processor. It accepts a program as a valid/ready word stream and writes it into instruction memory from address 0. It then pulses the processor's `start`, counts execution cycles until the processor raises `stop`, and reports word count, cycle count and error status. It owns the instruction-memory write port; the processor keeps the read port.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory address width
- `DATA_WIDTH`, 16, instruction word width
- `CNT_WIDTH`, 16, execution cycle counter width
- `MAX_CYCLES`, 1000, run timeout in cycles; must be < 2^CNT_WIDTH

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `load_req`  in  1  begin a load; honoured only in IDLE and DONE
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  stream ready
- `s_data`  in  DATA_WIDTH  program word
- `s_last`  in  1  marks the final program word
- `im_wr`  out  1  instruction-memory write enable
- `im_w_addr`  out  ADDR_WIDTH  write address
- `im_w_data`  out  DATA_WIDTH  write data
- `start`  out  1  one-cycle pulse to the processor
- `stop`  in  1  processor stopped flag
- `busy`  out  1  state is not IDLE or DONE
- `done`  out  1  run finished, normally or with an error
- `err_code`  out  2  0 none, 1 overflow, 2 timeout
- `word_count`  out  ADDR_WIDTH+1  words accepted in the current load
- `cycle_count`  out  CNT_WIDTH  RUN cycles with `stop` low

## Operation
- States: IDLE, LOAD, FLUSH, START, RUN, DONE.
- IDLE:
  - `s_ready`=0.
  - `load_req`=1 → LOAD. On the same edge, clear `word_count`, `cycle_count`, `err_code` and `done`, and set the address to 0.
- LOAD:
  - `s_ready`=1.
  - Each handshake (`s_valid`&`s_ready`) registers `im_w_addr`=addr and `im_w_data`=`s_data`, and sets `im_wr`=1 for the next cycle. Then addr+1 and `word_count`+1.
  - Handshake with `s_last` → FLUSH.
  - Handshake at addr 2^ADDR_WIDTH−1 without `s_last`: the word is written, `err_code`=1, → DONE. The processor is not started.
- FLUSH:
  - `s_ready`=0.
  - The last write is on the bus (`im_wr`=1). Next state START.
- START:
  - `start`=1 for exactly this cycle; `cycle_count`=0. Next state RUN.
- RUN:
  - `stop` is sampled only in RUN.
  - `stop`=0: `cycle_count`+1.
  - `stop`=1: the count freezes, → DONE, `err_code` stays 0.
  - `cycle_count`==MAX_CYCLES with `stop`=0: `err_code`=2, → DONE, no increment.
- DONE:
  - `done`=1. All counts and `err_code` hold.
  - `load_req` → LOAD, with the same clears as from IDLE.
- `load_req` is ignored in LOAD, FLUSH, START and RUN.
- `s_valid` is ignored whenever `s_ready`=0. `s_data` is never captured outside LOAD.

## Timing
- Reset values: state IDLE. All outputs are 0: `s_ready`, `im_wr`, `im_w_addr`, `im_w_data`, `start`, `busy`, `done`, `err_code`, `word_count`, `cycle_count`.
- All outputs are registered except `s_ready` and `busy`, which are decoded from the state register.
- Write latency: a handshake at cycle N gives `im_wr`=1 at N+1. Back-to-back handshakes give back-to-back writes.
- Last handshake at cycle N:
  - N+1: FLUSH, last write on the bus.
  - N+2: `start` pulse.
  - N+3: first RUN cycle.
- A `stop` rise at RUN cycle k (k≥0) gives `done`=1 at k+1 and `cycle_count`=k.
- Single-word program: LOAD, FLUSH, START, RUN in consecutive cycles.
- `rst` mid-operation:
  - All state returns to IDLE on the next edge, and `im_wr` drops on that edge.
  - A partially loaded memory is left as is, with no cleanup.
  - `start` is never issued after reset until a new full load completes.

## Structure
- `boot_pkg`: state enum, `err_code` localparams (`ERR_NONE`, `ERR_OVF`, `ERR_TMO`), default widths.
- Single module, no sub-modules. The counters are plain registers inside `boot_ctrl`.

## Test plan
- 4-word load 0x1111, 0x2222, 0x3333, 0x4444 (last on word 4), stream always valid → writes to addresses 0–3 on 4 consecutive cycles, `word_count`=4, `start` exactly 2 cycles after the last handshake.
- Stalled stream (`s_valid` toggling 1,0,1,0) → no `im_wr` in gap cycles, addresses still contiguous 0..3.
- `stop` raised 10 cycles into RUN → `done`=1, `cycle_count`=10, `err_code`=0. `load_req` pulsed during RUN beforehand → no effect.
- 257 words, no `s_last` → 256 writes (addresses 0–255), `err_code`=1, `done`=1, `word_count`=256, `start` never pulses.
- `stop` held low, MAX_CYCLES=20 → `done` after `cycle_count`=20, `err_code`=2. New `load_req` → counters clear and the load restarts at address 0.
- `rst` asserted after 2 of 4 words → IDLE next edge, all outputs 0. A subsequent 1-word load starts at address 0 with `word_count`=1.
